// File: rtl/mac_pkg.sv
// Shared types and constants for the four-lane FP32 MAC driver.
// The per-step pipeline tag travels alongside the BRAM read latency.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FULL,
        DRAIN,
        DONE
    } state_t;

    localparam int          EXP_BIAS   = 127;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam int          BRAM_WORDS = 1024;

    typedef struct packed {
        logic       rd;
        logic       first;
        logic       fin;
        logic       zero;
        logic       last_o;
        logic       blkend;
        logic [9:0] waddr;
    } step_t;

endpackage

// File: rtl/fp_mac.sv
// Single-cycle FP32 multiply then add (two RNE roundings) into a registered accumulator.
// Denormals flush to signed zero, overflow saturates to infinity, any NaN becomes QNAN.
module fp_mac
    import mac_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] acc
);

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       r;
        logic              s;
        logic [7:0]        ex, ey;
        logic [47:0]       p;
        logic [23:0]       m;
        logic              g, st;
        logic signed [9:0] e;
        ex = x[30:23];
        ey = y[30:23];
        s  = x[31] ^ y[31];
        r  = {s, 31'd0};
        if (is_nan(x) || is_nan(y)) begin
            r = QNAN;
        end else if (ex == 8'hFF || ey == 8'hFF) begin
            r = (ex == 8'd0 || ey == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
        end else if (ex != 8'd0 && ey != 8'd0) begin
            p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
            e = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'(EXP_BIAS);
            if (p[47]) begin
                m  = {1'b0, p[46:24]};
                g  = p[23];
                st = |p[22:0];
                e  = e + 10'sd1;
            end else begin
                m  = {1'b0, p[45:23]};
                g  = p[22];
                st = |p[21:0];
            end
            if (g && (st || m[0])) m = m + 24'd1;
            if (m[23]) begin
                m = 24'd0;
                e = e + 10'sd1;
            end
            if (e >= 10'sd255)   r = {s, 8'hFF, 23'd0};
            else if (e <= 10'sd0) r = {s, 31'd0};
            else                  r = {s, e[7:0], m[22:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       r, big, sml;
        logic [7:0]        ex, ey, d;
        logic [26:0]       mb, ms, mask;
        logic [27:0]       sum;
        logic              sticky, g, rs;
        logic [4:0]        lz;
        logic [23:0]       m;
        logic signed [9:0] e;
        ex = x[30:23];
        ey = y[30:23];
        r  = 32'd0;
        if (is_nan(x) || is_nan(y)) begin
            r = QNAN;
        end else if (ex == 8'hFF && ey == 8'hFF) begin
            r = (x[31] == y[31]) ? {x[31], 8'hFF, 23'd0} : QNAN;
        end else if (ex == 8'hFF) begin
            r = {x[31], 8'hFF, 23'd0};
        end else if (ey == 8'hFF) begin
            r = {y[31], 8'hFF, 23'd0};
        end else if (ex == 8'd0 && ey == 8'd0) begin
            r = {x[31] & y[31], 31'd0};
        end else if (ex == 8'd0) begin
            r = y;
        end else if (ey == 8'd0) begin
            r = x;
        end else begin
            if (x[30:0] >= y[30:0]) begin
                big = x;
                sml = y;
            end else begin
                big = y;
                sml = x;
            end
            d  = big[30:23] - sml[30:23];
            mb = {1'b1, big[22:0], 3'b000};
            ms = {1'b1, sml[22:0], 3'b000};
            // three extra bits act as guard, round and sticky
            if (d >= 8'd27) begin
                ms = 27'd1;
            end else begin
                mask   = (27'd1 << d) - 27'd1;
                sticky = |(ms & mask);
                ms     = (ms >> d) | {26'd0, sticky};
            end
            e = $signed({2'b00, big[30:23]});
            if (big[31] == sml[31]) begin
                sum = {1'b0, mb} + {1'b0, ms};
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                    e   = e + 10'sd1;
                end
            end else begin
                sum = {1'b0, mb} - {1'b0, ms};
                lz  = 5'd0;
                for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
                sum = sum << lz;
                e   = e - $signed({5'b0, lz});
            end
            if (sum != 28'd0) begin
                m  = {1'b0, sum[25:3]};
                g  = sum[2];
                rs = sum[1] | sum[0];
                if (g && (rs || m[0])) m = m + 24'd1;
                if (m[23]) begin
                    m = 24'd0;
                    e = e + 10'sd1;
                end
                if (e >= 10'sd255)    r = {big[31], 8'hFF, 23'd0};
                else if (e <= 10'sd0) r = {big[31], 31'd0};
                else                  r = {big[31], e[7:0], m[22:0]};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= 32'd0;
        end else if (en) begin
            acc <= fp_add(fp_mul(a, b), clr ? 32'd0 : acc);
        end
    end

endmodule

// File: rtl/driver.sv
// Four-lane FP32 MAC controller: streams operands from BRAM, accumulates, writes
// results block by block under the PS run/ack handshake.
//
// state | meaning
// IDLE  | waiting for ps_control[0]; parameters latched on exit
// RUN   | issuing reads and writing results for the current block
// FULL  | output block full, pl_full[0]=1, waiting for PS ack low
// DRAIN | PS reading the block, waiting for ps_control[0] high to resume
// DONE  | all results written, pl_status[0]=1 until ps_control[0] low
module driver
    import mac_pkg::*;
#(
    parameter int BLOCK_WORDS = 1024,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ps_control,
    input  logic [31:0]       ps_iternum,
    input  logic [31:0]       ps_accfreq,
    input  logic [31:0]       ps_phase,
    output logic [31:0]       pl_status,
    output logic [31:0]       pl_full,
    output logic [ADDR_W-1:0] in0_bram0_addr,
    output logic [ADDR_W-1:0] in0_bram1_addr,
    output logic [ADDR_W-1:0] in0_bram2_addr,
    output logic [ADDR_W-1:0] in0_bram3_addr,
    input  logic [31:0]       in0_bram0_rddata,
    input  logic [31:0]       in0_bram1_rddata,
    input  logic [31:0]       in0_bram2_rddata,
    input  logic [31:0]       in0_bram3_rddata,
    output logic [ADDR_W-1:0] in1_bram_addr,
    input  logic [31:0]       in1_bram_rddata,
    output logic [ADDR_W-1:0] out_bram0_addr,
    output logic [ADDR_W-1:0] out_bram1_addr,
    output logic [ADDR_W-1:0] out_bram2_addr,
    output logic [ADDR_W-1:0] out_bram3_addr,
    output logic [31:0]       out_bram0_wrdata,
    output logic [31:0]       out_bram1_wrdata,
    output logic [31:0]       out_bram2_wrdata,
    output logic [31:0]       out_bram3_wrdata,
    output logic [3:0]        out_bram0_we,
    output logic [3:0]        out_bram1_we,
    output logic [3:0]        out_bram2_we,
    output logic [3:0]        out_bram3_we
);

    localparam int WW = ADDR_W - 2;

    state_t            state, state_nx;
    logic              start, resume, issuing;
    logic [31:0]       itn, acf, o_cnt, j_cnt;
    logic [3:0]        phase;
    logic [WW-1:0]     lin;
    logic [9:0]        oblk;
    logic              iss_en, last_j, last_o, blkend;
    logic [ADDR_W-1:0] in0_addr, in1_addr, wr_addr;
    step_t             step, s1, s2, wr;
    logic [31:0]       a_lane [4];
    logic [31:0]       acc    [4];
    logic [31:0]       wr_data[4];
    logic              unused_ok;

    assign unused_ok = ^{ps_control[31:1], ps_phase[31:4]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        resume   = 1'b0;
        case (state)
            IDLE: begin
                if (ps_control[0]) begin
                    if (ps_iternum == 32'd0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                        start    = 1'b1;
                    end
                end
            end
            RUN: begin
                // the last block goes to DONE even when it is exactly full
                if (wr.fin && wr.last_o)      state_nx = DONE;
                else if (wr.fin && wr.blkend) state_nx = FULL;
            end
            FULL:  if (!ps_control[0]) state_nx = DRAIN;
            DRAIN: begin
                if (ps_control[0]) begin
                    state_nx = RUN;
                    resume   = 1'b1;
                end
            end
            DONE:    if (!ps_control[0]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        issuing = iss_en && (state == RUN);
        last_j  = (acf == 32'd0) || (j_cnt == acf - 32'd1);
        last_o  = (o_cnt == itn - 32'd1);
        blkend  = (oblk == 10'(BLOCK_WORDS - 1));
        step    = '0;
        if (issuing) begin
            step.rd     = (acf != 32'd0);
            step.first  = (j_cnt == 32'd0);
            step.fin    = last_j;
            step.zero   = (acf == 32'd0);
            step.last_o = last_o;
            step.blkend = blkend;
            step.waddr  = oblk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            itn      <= 32'd0;
            acf      <= 32'd0;
            phase    <= 4'd0;
            o_cnt    <= 32'd0;
            j_cnt    <= 32'd0;
            lin      <= '0;
            oblk     <= 10'd0;
            iss_en   <= 1'b0;
            in0_addr <= '0;
            in1_addr <= '0;
            s1       <= '0;
            s2       <= '0;
            wr       <= '0;
        end else begin
            s1 <= step;
            s2 <= s1;
            wr <= s2;
            if (state == IDLE && ps_control[0]) begin
                itn   <= ps_iternum;
                acf   <= ps_accfreq;
                phase <= ps_phase[3:0];
            end
            if (start) begin
                o_cnt  <= 32'd0;
                j_cnt  <= 32'd0;
                lin    <= '0;
                oblk   <= 10'd0;
                iss_en <= 1'b1;
            end else if (resume) begin
                oblk   <= 10'd0;
                iss_en <= 1'b1;
            end else if (issuing) begin
                if (acf != 32'd0) begin
                    in0_addr <= {lin, 2'b00};
                    in1_addr <= {j_cnt[WW-1:0], 2'b00};
                    lin      <= lin + 1'b1;
                end
                if (last_j) begin
                    j_cnt <= 32'd0;
                    o_cnt <= o_cnt + 32'd1;
                    oblk  <= blkend ? 10'd0 : oblk + 10'd1;
                    if (last_o || blkend) iss_en <= 1'b0;
                end else begin
                    j_cnt <= j_cnt + 32'd1;
                end
            end
        end
    end

    assign a_lane[0] = in0_bram0_rddata;
    assign a_lane[1] = in0_bram1_rddata;
    assign a_lane[2] = in0_bram2_rddata;
    assign a_lane[3] = in0_bram3_rddata;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        fp_mac u_mac (
            .clk   (clk),
            .reset (reset),
            .en    (s2.rd),
            .clr   (s2.first),
            .a     (a_lane[k]),
            .b     (in1_bram_rddata),
            .acc   (acc[k])
        );
        assign wr_data[k] = wr.zero ? 32'd0 : acc[k];
    end

    assign wr_addr = ADDR_W'({wr.waddr, 2'b00});

    assign in0_bram0_addr   = in0_addr;
    assign in0_bram1_addr   = in0_addr;
    assign in0_bram2_addr   = in0_addr;
    assign in0_bram3_addr   = in0_addr;
    assign in1_bram_addr    = in1_addr;
    assign out_bram0_addr   = wr_addr;
    assign out_bram1_addr   = wr_addr;
    assign out_bram2_addr   = wr_addr;
    assign out_bram3_addr   = wr_addr;
    assign out_bram0_wrdata = wr_data[0];
    assign out_bram1_wrdata = wr_data[1];
    assign out_bram2_wrdata = wr_data[2];
    assign out_bram3_wrdata = wr_data[3];
    assign out_bram0_we     = wr.fin ? 4'hF : 4'h0;
    assign out_bram1_we     = wr.fin ? 4'hF : 4'h0;
    assign out_bram2_we     = wr.fin ? 4'hF : 4'h0;
    assign out_bram3_we     = wr.fin ? 4'hF : 4'h0;
    assign pl_status        = {24'd0, phase, 3'd0, state == DONE};
    assign pl_full          = {31'd0, state == FULL};

endmodule

// File: tb/tb_driver.sv
// Scoreboard bench for driver: stimulus pushes expected writes, a forked monitor
// pops and compares every output BRAM write.
module tb_driver;

    typedef struct packed {
        logic [11:0]      addr;
        logic [3:0][31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ps_control, ps_iternum, ps_accfreq, ps_phase;
    logic [31:0] pl_status, pl_full;
    logic [11:0] in0_addr [4];
    logic [31:0] in0_rd   [4];
    logic [11:0] in1_addr;
    logic [31:0] in1_rd;
    logic [11:0] out_addr [4];
    logic [31:0] out_data [4];
    logic [3:0]  out_we   [4];

    logic [31:0] in0_mem [4][1024];
    logic [31:0] in1_mem [1024];

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    driver #(.BLOCK_WORDS(4), .ADDR_W(12)) dut (
        .clk              (clk),
        .reset            (reset),
        .ps_control       (ps_control),
        .ps_iternum       (ps_iternum),
        .ps_accfreq       (ps_accfreq),
        .ps_phase         (ps_phase),
        .pl_status        (pl_status),
        .pl_full          (pl_full),
        .in0_bram0_addr   (in0_addr[0]),
        .in0_bram1_addr   (in0_addr[1]),
        .in0_bram2_addr   (in0_addr[2]),
        .in0_bram3_addr   (in0_addr[3]),
        .in0_bram0_rddata (in0_rd[0]),
        .in0_bram1_rddata (in0_rd[1]),
        .in0_bram2_rddata (in0_rd[2]),
        .in0_bram3_rddata (in0_rd[3]),
        .in1_bram_addr    (in1_addr),
        .in1_bram_rddata  (in1_rd),
        .out_bram0_addr   (out_addr[0]),
        .out_bram1_addr   (out_addr[1]),
        .out_bram2_addr   (out_addr[2]),
        .out_bram3_addr   (out_addr[3]),
        .out_bram0_wrdata (out_data[0]),
        .out_bram1_wrdata (out_data[1]),
        .out_bram2_wrdata (out_data[2]),
        .out_bram3_wrdata (out_data[3]),
        .out_bram0_we     (out_we[0]),
        .out_bram1_we     (out_we[1]),
        .out_bram2_we     (out_we[2]),
        .out_bram3_we     (out_we[3])
    );

    // BRAM models, one cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) in0_rd[k] <= in0_mem[k][in0_addr[k][11:2]];
        in1_rd <= in1_mem[in1_addr[11:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
        exp_t e;
        e.addr = a;
        e.d[0] = d0;
        e.d[1] = d1;
        e.d[2] = d2;
        e.d[3] = d3;
        exp_q.push_back(e);
    endtask

    task automatic fill(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] a3, input logic [31:0] b);
        for (int i = 0; i < 64; i++) begin
            in0_mem[0][i] = a0;
            in0_mem[1][i] = a1;
            in0_mem[2][i] = a2;
            in0_mem[3][i] = a3;
            in1_mem[i]    = b;
        end
    endtask

    task automatic wait_bit(input string name, input bit use_full, input logic val, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if ((use_full ? pl_full[0] : pl_status[0]) == val) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s timeout: bit never reached %0d within %0d cycles", name, val, budget);
        end
    endtask

    task automatic drained(input string name);
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic start_run(input int it, input int af, input int ph);
        ps_iternum = 32'(it);
        ps_accfreq = 32'(af);
        ps_phase   = 32'(ph);
        ps_control = 32'd1;
    endtask

    task automatic end_run(input string name);
        wait_bit({name, "_done"}, 1'b0, 1'b1, 200);
        repeat (3) @(negedge clk);
        drained({name, "_writes"});
        ps_control = 32'd0;
        repeat (2) @(negedge clk);
        chk({name, "_status_clear"}, pl_status[0], 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        ps_control = 32'd0;
        ps_iternum = 32'd0;
        ps_accfreq = 32'd0;
        ps_phase   = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            for (int k = 0; k < 4; k++) in0_mem[k][i] = 32'd0;
            in1_mem[i] = 32'd0;
        end

        fork
            forever begin
                @(negedge clk);
                if ((out_we[0] | out_we[1] | out_we[2] | out_we[3]) != 4'h0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual addr=%h data0=%h required no write",
                                 out_addr[0], out_data[0]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        for (int k = 0; k < 4; k++) begin
                            chk($sformatf("we%0d", k), {28'd0, out_we[k]}, 32'hF);
                            chk($sformatf("addr%0d", k), {20'd0, out_addr[k]}, {20'd0, mon_e.addr});
                            chk($sformatf("data%0d", k), out_data[k], mon_e.d[k]);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_status", pl_status, 32'd0);
        chk("rst_full", pl_full, 32'd0);
        chk("rst_we", {16'd0, out_we[0], out_we[1], out_we[2], out_we[3]}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // basic: 4.0*1.0 summed four times
        fill(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h3F800000);
        for (int o = 0; o < 3; o++) push(12'(o * 4), 32'h41800000, 32'h41800000, 32'h41800000, 32'h41800000);
        start_run(3, 4, 0);
        end_run("basic");

        // block handshake: BLOCK_WORDS=4, ten outputs
        fill(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h40000000);
        for (int o = 0; o < 10; o++) push(12'((o % 4) * 4), 32'h41800000, 32'h41800000, 32'h41800000, 32'h41800000);
        start_run(10, 2, 0);
        for (int h = 0; h < 2; h++) begin
            wait_bit($sformatf("full%0d_set", h), 1'b1, 1'b1, 100);
            repeat (5) @(negedge clk);
            chk($sformatf("full%0d_hold", h), pl_full, 32'd1);
            chk($sformatf("full%0d_pending", h), 32'(exp_q.size()), 32'(10 - 4 * (h + 1)));
            ps_control = 32'd0;
            @(negedge clk);
            chk($sformatf("full%0d_drain", h), pl_full, 32'd0);
            ps_control = 32'd1;
        end
        end_run("block");
        chk("block_never_full_at_end", pl_full, 32'd0);

        // reset in the middle of a run
        fill(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h3F800000);
        start_run(3, 4, 5);
        repeat (4) @(negedge clk);
        chk("midrun_status", pl_status, 32'h50);
        #2 reset = 1'b0;
        #1;
        chk("async_status", pl_status, 32'd0);
        chk("async_full", pl_full, 32'd0);
        chk("async_we", {16'd0, out_we[0], out_we[1], out_we[2], out_we[3]}, 32'd0);
        chk("async_addr", {20'd0, in0_addr[0]}, 32'd0);
        ps_control = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int o = 0; o < 3; o++) push(12'(o * 4), 32'h41800000, 32'h41800000, 32'h41800000, 32'h41800000);
        start_run(3, 4, 0);
        end_run("restart");

        // iternum = 0 goes straight to DONE, no writes
        start_run(0, 4, 0);
        @(negedge clk);
        chk("zero_iter_done", pl_status, 32'd1);
        repeat (4) @(negedge clk);
        ps_control = 32'd0;
        repeat (2) @(negedge clk);
        chk("zero_iter_clear", pl_status, 32'd0);

        // special values: overflow, denormal, NaN, negative overflow
        fill(32'h7F7FFFFF, 32'h00000001, 32'h7FC00001, 32'hFF7FFFFF, 32'h40000000);
        push(12'd0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000);
        start_run(1, 1, 0);
        end_run("special");

        // per-word addressing, distinct lanes, round-half-even ties
        fill(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        in0_mem[0][0] = 32'h3F800000; in0_mem[0][1] = 32'h40000000;
        in0_mem[0][2] = 32'h40400000; in0_mem[0][3] = 32'h40800000;
        in0_mem[1][0] = 32'hBF800000; in0_mem[1][1] = 32'hC0000000;
        in0_mem[1][2] = 32'hC0400000; in0_mem[1][3] = 32'hC0800000;
        for (int i = 0; i < 4; i++) in0_mem[2][i] = 32'h3F000000;
        in0_mem[3][0] = 32'h3F800001; in0_mem[3][1] = 32'h3F000000;
        in0_mem[3][2] = 32'h3F800003; in0_mem[3][3] = 32'h3F000000;
        in1_mem[0] = 32'h3F800000;
        in1_mem[1] = 32'h40000000;
        push(12'd0, 32'h40A00000, 32'hC0A00000, 32'h3FC00000, 32'h40000000);
        push(12'd4, 32'h41300000, 32'hC1300000, 32'h3FC00000, 32'h40000002);
        start_run(2, 2, 0);
        end_run("lanes");

        // phase tag, and a ps_control drop during RUN is ignored
        fill(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h3F800000);
        for (int o = 0; o < 2; o++) push(12'(o * 4), 32'h41400000, 32'h41400000, 32'h41400000, 32'h41400000);
        start_run(2, 3, 3);
        repeat (2) @(negedge clk);
        chk("phase_run", pl_status, 32'h30);
        ps_control = 32'd0;
        repeat (3) @(negedge clk);
        chk("phase_drop_status", pl_status, 32'h30);
        chk("phase_drop_full", pl_full, 32'd0);
        ps_control = 32'd1;
        wait_bit("phase_done", 1'b0, 1'b1, 100);
        chk("phase_done_status", pl_status, 32'h31);
        repeat (2) @(negedge clk);
        drained("phase_writes");
        ps_control = 32'd0;
        repeat (2) @(negedge clk);
        chk("phase_clear", pl_status[0], 32'd0);

        // accfreq = 0 writes +0.0 per output
        fill(32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000, 32'h3F800000);
        push(12'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        push(12'd4, 32'd0, 32'd0, 32'd0, 32'd0);
        start_run(2, 0, 0);
        end_run("zero_acc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
